// File: rtl/cache_fill_if.sv
// Signal bundle between the cache miss controller, the L1 arrays and main memory.
// master is the fill controller; slave is the cache/memory side.
interface cache_fill_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned OFF_W  = 3
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [15:0]       memory_data;
  logic              fsm_busy;
  logic              memory_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [OFF_W-1:0]  fill_word_offset;
  logic [15:0]       fill_data;
  logic              write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_en, memory_address, write_data_array, fill_word_offset,
           fill_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_en, memory_address, write_data_array, fill_word_offset,
           fill_data, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches the aligned block around a miss address one word per
// cycle from main memory, steers returns into the data array, then writes the tag array.
module cache_fill_fsm #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cache_fill_if.master  bus
);

  localparam int unsigned OffW = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CntW = OffW + 1;

  typedef enum logic {StIdle, StFill} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] block_base_q;
  logic [CntW-1:0]   issue_cnt_q;
  logic [OffW-1:0]   recv_cnt_q;

  logic issue_pending;
  logic in_fill;
  logic last_word;

  assign in_fill       = (state_q == StFill);
  assign issue_pending = in_fill && (issue_cnt_q < CntW'(WORDS_PER_BLOCK));
  assign last_word     = (recv_cnt_q == OffW'(WORDS_PER_BLOCK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      block_base_q <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.miss_detected) begin
            // Block is 2*WORDS_PER_BLOCK bytes, so clear the byte-in-block bits.
            block_base_q <= bus.miss_address & ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            state_q      <= StFill;
          end
        end
        StFill: begin
          if (issue_pending) begin
            issue_cnt_q <= issue_cnt_q + CntW'(1);
          end
          if (bus.memory_data_valid) begin
            // Wraps back to zero on the final word, leaving the offset clean in idle.
            recv_cnt_q <= recv_cnt_q + OffW'(1);
            if (last_word) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.fsm_busy         = in_fill;
    bus.memory_en        = issue_pending;
    bus.memory_address   = block_base_q;
    if (issue_pending) begin
      bus.memory_address = block_base_q + (ADDR_W'(issue_cnt_q) << 1);
    end
    bus.write_data_array = in_fill && bus.memory_data_valid;
    bus.fill_word_offset = recv_cnt_q;
    bus.fill_data        = bus.memory_data;
    bus.write_tag_array  = in_fill && bus.memory_data_valid && last_word;
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a reference model of busy/issue/receive state,
// a latency-programmable memory model, and a scoreboard of expected data-array writes.
module tb_cache_fill_fsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_fill_if bus ();

  cache_fill_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          cyc;
  int          ret_due[$];
  logic [15:0] ret_data[$];
  int          last_due;
  bit          gap_mode;
  int          lat;
  bit          stray_en;

  int          sb_off[$];
  logic [15:0] sb_data[$];

  bit          m_busy;
  logic [15:0] m_base;
  int          m_issue;
  int          m_recv;

  int          t0;
  int          tag_cyc;
  int          first_issue_cyc;
  int          first_wr_cyc;
  logic [15:0] first_addr;
  logic [15:0] last_addr;
  int          wr_cnt;
  int          tag_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_func(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_base  = '0;
    m_issue = 0;
    m_recv  = 0;
    sb_off.delete();
    sb_data.delete();
  endtask

  task automatic reset_marks();
    tag_cyc         = -1;
    first_issue_cyc = -1;
    first_wr_cyc    = -1;
    wr_cnt          = 0;
    tag_cnt         = 0;
    last_due        = cyc;
  endtask

  // Drive phase: memory returns and stray valids, 1 time unit after the rising edge.
  task automatic begin_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (ret_due.size() > 0 && ret_due[0] == cyc) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = ret_data.pop_front();
      void'(ret_due.pop_front());
    end else if (stray_en && ($urandom_range(0, 1) == 1)) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'($urandom);
    end else begin
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'($urandom);
    end
  endtask

  // Sample phase on the falling edge: compare against the model, then advance it.
  task automatic end_cycle();
    logic        e_en, e_wr, e_tag;
    logic [15:0] e_addr;
    int          due;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_busy", bus.fsm_busy, 0);
      check("rst_en", bus.memory_en, 0);
      check("rst_addr", bus.memory_address, 0);
      check("rst_wr", bus.write_data_array, 0);
      check("rst_off", bus.fill_word_offset, 0);
      check("rst_tag", bus.write_tag_array, 0);
      model_reset();
    end else begin
      e_en   = m_busy && (m_issue < 8);
      e_wr   = m_busy && bus.memory_data_valid;
      e_tag  = e_wr && (m_recv == 7);
      e_addr = m_base + 16'(2 * m_issue);
      check("busy", bus.fsm_busy, m_busy);
      check("mem_en", bus.memory_en, e_en);
      check("wr_data", bus.write_data_array, e_wr);
      check("wr_tag", bus.write_tag_array, e_tag);
      check("fill_data", bus.fill_data, bus.memory_data);
      if (bus.memory_en) begin
        if (e_en) check("mem_addr", bus.memory_address, e_addr);
        if (first_issue_cyc < 0) begin
          first_issue_cyc = cyc;
          first_addr      = bus.memory_address;
        end
        last_addr = bus.memory_address;
        due = gap_mode ? last_due + $urandom_range(1, 6) : cyc + lat;
        if (due <= cyc) due = cyc + 1;
        last_due = due;
        ret_due.push_back(due);
        ret_data.push_back(mem_func(bus.memory_address));
      end
      if (e_en) begin
        sb_off.push_back(m_issue);
        sb_data.push_back(mem_func(e_addr));
      end
      if (bus.write_data_array) begin
        wr_cnt++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        if (sb_off.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          check("wr_offset", bus.fill_word_offset, sb_off.pop_front());
          check("wr_word", bus.fill_data, sb_data.pop_front());
        end
      end
      if (bus.write_tag_array) begin
        tag_cnt++;
        tag_cyc = cyc;
      end
      if (!m_busy) begin
        if (bus.miss_detected) begin
          m_busy  = 1'b1;
          m_base  = bus.miss_address & 16'hFFF0;
          m_issue = 0;
          m_recv  = 0;
        end
      end else begin
        if (m_issue < 8) m_issue++;
        if (bus.memory_data_valid) begin
          m_recv++;
          if (m_recv == 8) m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      bus.miss_detected = 1'b0;
      end_cycle();
    end
  endtask

  task automatic start_fill(input logic [15:0] addr);
    begin_cycle();
    reset_marks();
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    t0 = cyc;
    end_cycle();
  endtask

  task automatic run_until_tag(input int drop_off);
    for (int i = 0; i < 200; i++) begin
      if (tag_cyc >= 0) break;
      begin_cycle();
      if (cyc - t0 == drop_off) bus.miss_detected = 1'b0;
      end_cycle();
    end
    check("tag_seen", tag_cyc >= 0, 1);
  endtask

  int tag1;

  initial begin
    rst_n                 = 1'b0;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = '0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = '0;
    cyc      = 0;
    lat      = 4;
    gap_mode = 1'b0;
    stray_en = 1'b0;
    model_reset();
    reset_marks();

    begin_cycle();
    end_cycle();
    begin_cycle();
    rst_n = 1'b1;
    end_cycle();
    idle(2);

    // Basic fill with 4-cycle memory.
    start_fill(16'h1234);
    run_until_tag(1000);
    check("basic_first_issue", first_issue_cyc - t0, 1);
    check("basic_first_addr", first_addr, 16'h1230);
    check("basic_last_addr", last_addr, 16'h123E);
    check("basic_first_wr", first_wr_cyc - t0, 5);
    check("basic_tag_cyc", tag_cyc - t0, 12);
    check("basic_wr_cnt", wr_cnt, 8);
    check("basic_tag_cnt", tag_cnt, 1);
    idle(3);

    // Top of memory: no wrap past 0xFFFE.
    start_fill(16'hFFFE);
    run_until_tag(1000);
    check("top_first_addr", first_addr, 16'hFFF0);
    check("top_last_addr", last_addr, 16'hFFFE);
    check("top_wr_cnt", wr_cnt, 8);
    check("top_tag_cyc", tag_cyc - t0, 12);
    idle(3);

    // Miss dropped mid-fill.
    start_fill(16'h0A5A);
    run_until_tag(3);
    check("drop_wr_cnt", wr_cnt, 8);
    check("drop_tag_cnt", tag_cnt, 1);
    check("drop_tag_cyc", tag_cyc - t0, 12);
    idle(3);

    // Reset in cycle 6 of a fill; late returns must be ignored.
    start_fill(16'h5557);
    for (int i = 0; i < 5; i++) begin
      begin_cycle();
      end_cycle();
    end
    begin_cycle();
    rst_n             = 1'b0;
    bus.miss_detected = 1'b0;
    end_cycle();
    reset_marks();
    begin_cycle();
    rst_n = 1'b1;
    end_cycle();
    idle(7);
    check("rst_late_wr_cnt", wr_cnt, 0);
    check("rst_late_tag_cnt", tag_cnt, 0);
    check("rst_ret_drained", ret_due.size(), 0);

    // Back-to-back: miss held high, new address in the idle cycle after completion.
    start_fill(16'h0040);
    run_until_tag(1000);
    check("b2b_first_addr", first_addr, 16'h0040);
    tag1 = tag_cyc;
    begin_cycle();
    reset_marks();
    bus.miss_address = 16'h2000;
    t0 = cyc;
    end_cycle();
    check("b2b_gap_cyc", t0 - tag1, 1);
    run_until_tag(2);
    check("b2b2_first_issue", first_issue_cyc - t0, 1);
    check("b2b2_first_addr", first_addr, 16'h2000);
    check("b2b2_wr_cnt", wr_cnt, 8);
    idle(3);

    // Stray valids in idle, then variable-gap memory.
    reset_marks();
    stray_en = 1'b1;
    idle(12);
    stray_en = 1'b0;
    check("stray_wr_cnt", wr_cnt, 0);
    check("stray_tag_cnt", tag_cnt, 0);
    gap_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_fill(16'h7ABC + 16'(k * 16'h0313));
      run_until_tag(4);
      check("gap_wr_cnt", wr_cnt, 8);
      check("gap_tag_cnt", tag_cnt, 1);
      idle(2);
    end
    gap_mode = 1'b0;

    check("sb_empty", sb_off.size(), 0);
    check("ret_empty", ret_due.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
